// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file access arbiter: FSM states,
// RF function codes, address map and round-robin pointer values.
package rf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  localparam logic [2:0] ADDR_T1 = 3'd0;
  localparam logic [2:0] ADDR_T2 = 3'd1;
  localparam logic [2:0] ADDR_T3 = 3'd2;
  localparam logic [2:0] ADDR_T4 = 3'd3;
  localparam logic [2:0] ADDR_R1 = 3'd4;
  localparam logic [2:0] ADDR_R2 = 3'd5;
  localparam logic [2:0] ADDR_R3 = 3'd6;
  localparam logic [2:0] ADDR_R4 = 3'd7;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  // True when the address names one of the R registers rather than a T register.
  function automatic logic is_raddr(input logic [2:0] addr);
    return (addr >= ADDR_R1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: one-hot grant {B,A} and the pointer value
// to keep when that grant is taken.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_ptr,
  output logic [1:0] o_gnt,
  output logic       o_ptr_next
);

  always_comb begin
    o_gnt      = 2'b00;
    o_ptr_next = i_ptr;
    if (i_req_a && i_req_b) begin
      o_gnt      = (i_ptr == PTR_A) ? 2'b01 : 2'b10;
      o_ptr_next = ~i_ptr;
    end else if (i_req_a) begin
      o_gnt      = 2'b01;
      o_ptr_next = PTR_B;
    end else if (i_req_b) begin
      o_gnt      = 2'b10;
      o_ptr_next = PTR_A;
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Arbitrates two requesters onto a single register file port; each operation
// runs IDLE -> ISSUE -> SETTLE -> RESP and returns the post-operation value.
module rf_access_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic [1:0]        OpA,
  input  logic [1:0]        OpB,
  input  logic [2:0]        AddrA,
  input  logic [2:0]        AddrB,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  output logic              AckA,
  output logic              AckB,
  output logic [DATA_W-1:0] RdData,
  output logic              Busy,
  output logic [DATA_W-1:0] RfInput,
  output logic [1:0]        RfFunSel,
  output logic [3:0]        RfRSel,
  output logic [3:0]        RfTSel,
  output logic [2:0]        RfO1Sel,
  input  logic [DATA_W-1:0] RfOut1
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;
  logic                w_ptr_nxt;
  logic [1:0]          w_gnt;
  logic                w_take;
  logic                w_sel_b;
  logic [1:0]          w_op_sel;
  logic [2:0]          w_addr_sel;
  logic [DATA_W-1:0]   w_data_sel;

  logic [2:0]          r_addr;
  logic                r_gnt_b;

  logic                r_ack_a;
  logic                r_ack_b;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rf_input;
  logic [1:0]          r_rf_fun_sel;
  logic [3:0]          r_rf_rsel;
  logic [3:0]          r_rf_tsel;
  logic [2:0]          r_rf_o1sel;

  logic                w_ack_a_nxt;
  logic                w_ack_b_nxt;
  logic [DATA_W-1:0]   w_rd_nxt;
  logic                w_busy_nxt;
  logic [DATA_W-1:0]   w_in_nxt;
  logic [1:0]          w_fun_nxt;
  logic [3:0]          w_rsel_nxt;
  logic [3:0]          w_tsel_nxt;
  logic [2:0]          w_o1_nxt;

  // Register index 0 maps to the MSB of the select vector (R1/T1).
  function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  rr_arb2 u_rr_arb2 (
    .i_req_a    (ReqA),
    .i_req_b    (ReqB),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_ptr_next (w_ptr_nxt)
  );

  assign w_take     = (r_state == ST_IDLE) && (|w_gnt);
  assign w_sel_b    = w_gnt[1];
  assign w_op_sel   = w_sel_b ? OpB   : OpA;
  assign w_addr_sel = w_sel_b ? AddrB : AddrA;
  assign w_data_sel = w_sel_b ? DataB : DataA;

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_a_nxt = 1'b0;
    w_ack_b_nxt = 1'b0;
    w_rd_nxt    = r_rd_data;
    w_in_nxt    = '0;
    w_fun_nxt   = '0;
    w_rsel_nxt  = '0;
    w_tsel_nxt  = '0;
    w_o1_nxt    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = ST_ISSUE;
          w_fun_nxt   = w_op_sel;
          w_in_nxt    = w_data_sel;
          if (is_raddr(w_addr_sel)) w_rsel_nxt = sel_onehot(w_addr_sel[1:0]);
          else                      w_tsel_nxt = sel_onehot(w_addr_sel[1:0]);
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_SETTLE;
        w_o1_nxt    = r_addr;
      end
      ST_SETTLE: begin
        w_state_nxt = ST_RESP;
        w_o1_nxt    = r_addr;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        w_rd_nxt    = RfOut1;
        w_ack_a_nxt = ~r_gnt_b;
        w_ack_b_nxt = r_gnt_b;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= PTR_A;
      r_addr       <= '0;
      r_gnt_b      <= 1'b0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_rd_data    <= '0;
      r_busy       <= 1'b0;
      r_rf_input   <= '0;
      r_rf_fun_sel <= '0;
      r_rf_rsel    <= '0;
      r_rf_tsel    <= '0;
      r_rf_o1sel   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      if (w_take) begin
        r_ptr   <= w_ptr_nxt;
        r_addr  <= w_addr_sel;
        r_gnt_b <= w_sel_b;
      end
      r_ack_a      <= w_ack_a_nxt;
      r_ack_b      <= w_ack_b_nxt;
      r_rd_data    <= w_rd_nxt;
      r_busy       <= w_busy_nxt;
      r_rf_input   <= w_in_nxt;
      r_rf_fun_sel <= w_fun_nxt;
      r_rf_rsel    <= w_rsel_nxt;
      r_rf_tsel    <= w_tsel_nxt;
      r_rf_o1sel   <= w_o1_nxt;
    end
  end

  assign AckA     = r_ack_a;
  assign AckB     = r_ack_b;
  assign RdData   = r_rd_data;
  assign Busy     = r_busy;
  assign RfInput  = r_rf_input;
  assign RfFunSel = r_rf_fun_sel;
  assign RfRSel   = r_rf_rsel;
  assign RfTSel   = r_rf_tsel;
  assign RfO1Sel  = r_rf_o1sel;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: behavioural register file on the RF port and a
// transaction-level model of arbitration order, timing and register contents.
module tb_rf_access_arbiter;

  localparam int DW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          ReqA, ReqB;
  logic [1:0]    OpA, OpB;
  logic [2:0]    AddrA, AddrB;
  logic [DW-1:0] DataA, DataB;
  logic          AckA, AckB;
  logic [DW-1:0] RdData;
  logic          Busy;
  logic [DW-1:0] RfInput;
  logic [1:0]    RfFunSel;
  logic [3:0]    RfRSel, RfTSel;
  logic [2:0]    RfO1Sel;
  logic [DW-1:0] RfOut1;

  always #5 Clock = ~Clock;

  rf_access_arbiter #(.DATA_W(DW)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .ReqB(ReqB), .OpA(OpA), .OpB(OpB),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
    .AckA(AckA), .AckB(AckB), .RdData(RdData), .Busy(Busy),
    .RfInput(RfInput), .RfFunSel(RfFunSel), .RfRSel(RfRSel), .RfTSel(RfTSel),
    .RfO1Sel(RfO1Sel), .RfOut1(RfOut1)
  );

  // Register file seen by the arbiter: T1..T4 and R1..R4, written on the selected bit.
  logic [DW-1:0] rf_t [4] = '{default: '0};
  logic [DW-1:0] rf_r [4] = '{default: '0};

  function automatic logic [DW-1:0] rf_fn(input logic [1:0] fs, input logic [DW-1:0] v,
                                          input logic [DW-1:0] d);
    case (fs)
      2'b00:   return '0;
      2'b01:   return d;
      2'b10:   return v - 1'b1;
      default: return v + 1'b1;
    endcase
  endfunction

  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (RfTSel[3-i]) rf_t[i] <= rf_fn(RfFunSel, rf_t[i], RfInput);
      if (RfRSel[3-i]) rf_r[i] <= rf_fn(RfFunSel, rf_r[i], RfInput);
    end
  end

  assign RfOut1 = RfO1Sel[2] ? rf_r[RfO1Sel[1:0]] : rf_t[RfO1Sel[1:0]];

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_rf [8];
  bit            turn;
  logic [DW-1:0] last_rd;
  logic [1:0]    s_op   [2];
  logic [2:0]    s_addr [2];
  logic [DW-1:0] s_dat  [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] v,
                                               input logic [DW-1:0] d);
    case (op)
      2'd0:    return '0;
      2'd1:    return d;
      2'd2:    return DW'((int'(v) + (1 << DW) - 1) % (1 << DW));
      default: return DW'((int'(v) + 1) % (1 << DW));
    endcase
  endfunction

  function automatic logic [3:0] exp_onehot(input logic [2:0] a);
    return 4'(1 << (3 - (int'(a) % 4)));
  endfunction

  task automatic set_req(input int w, input logic v);
    if (w == 0) ReqA = v; else ReqB = v;
  endtask

  task automatic scramble(input int w);
    if (w == 0) begin
      OpA = OpA ^ 2'b01; AddrA = AddrA ^ 3'b101; DataA = DataA ^ 8'h33;
    end else begin
      OpB = OpB ^ 2'b01; AddrB = AddrB ^ 3'b101; DataB = DataB ^ 8'h33;
    end
  endtask

  task automatic check_rf();
    for (int a = 0; a < 8; a++)
      check_eq("rf_content", (a < 4) ? rf_t[a] : rf_r[a-4], exp_rf[a]);
  endtask

  // One or two simultaneous requests, observed cycle by cycle until every Ack.
  task automatic run_scn(input bit enA, input bit enB,
                         input logic [1:0] oa, input logic [2:0] aa, input logic [DW-1:0] da,
                         input logic [1:0] ob, input logic [2:0] ab, input logic [DW-1:0] db,
                         input bit drA, input bit drB, input bit scA, input bit scB);
    int            order [2];
    bit            drop  [2];
    bit            scr   [2];
    int            nops;
    logic [DW-1:0] res;
    s_op[0] = oa; s_addr[0] = aa; s_dat[0] = da;
    s_op[1] = ob; s_addr[1] = ab; s_dat[1] = db;
    drop[0] = drA; drop[1] = drB; scr[0] = scA; scr[1] = scB;
    nops = int'(enA) + int'(enB);
    if (enA && enB) begin
      order[0] = turn ? 1 : 0;
      order[1] = 1 - order[0];
    end else begin
      order[0] = enB ? 1 : 0;
      order[1] = order[0];
    end
    turn = (order[nops-1] == 0);
    OpA = oa; AddrA = aa; DataA = da; ReqA = enA;
    OpB = ob; AddrB = ab; DataB = db; ReqB = enB;
    for (int n = 0; n < 4 * nops; n++) begin
      int g;
      int ph;
      @(posedge Clock); #1;
      g  = order[n / 4];
      ph = n % 4;
      check_eq("ack_a", AckA, (ph == 3) && (g == 0));
      check_eq("ack_b", AckB, (ph == 3) && (g == 1));
      check_eq("busy", Busy, ph != 3);
      if (ph == 0) begin
        check_eq("funsel", RfFunSel, s_op[g]);
        check_eq("rfinput", RfInput, s_dat[g]);
        check_eq("rsel_issue", RfRSel, (s_addr[g] >= 3'd4) ? exp_onehot(s_addr[g]) : 4'd0);
        check_eq("tsel_issue", RfTSel, (s_addr[g] <  3'd4) ? exp_onehot(s_addr[g]) : 4'd0);
        check_eq("rd_hold", RdData, last_rd);
        if (scr[g])  scramble(g);
        if (drop[g]) set_req(g, 1'b0);
      end else if (ph < 3) begin
        check_eq("rsel_idle", RfRSel, 4'd0);
        check_eq("tsel_idle", RfTSel, 4'd0);
        check_eq("o1sel", RfO1Sel, s_addr[g]);
        check_eq("rd_hold", RdData, last_rd);
      end else begin
        check_eq("rsel_ack", RfRSel, 4'd0);
        check_eq("tsel_ack", RfTSel, 4'd0);
        res = ref_result(s_op[g], exp_rf[s_addr[g]], s_dat[g]);
        exp_rf[s_addr[g]] = res;
        check_eq("rddata", RdData, res);
        last_rd = res;
        set_req(g, 1'b0);
      end
    end
  endtask

  initial begin
    int            cnt_a, cnt_b, who;
    logic [DW-1:0] res;
    bit            ea, eb;
    Reset = 1'b1;
    ReqA = 1'b0; ReqB = 1'b0; OpA = '0; OpB = '0;
    AddrA = '0; AddrB = '0; DataA = '0; DataB = '0;
    turn = 1'b0; last_rd = '0;
    for (int a = 0; a < 8; a++) exp_rf[a] = '0;

    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_acka", AckA, 0);
    check_eq("rst_ackb", AckB, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_rddata", RdData, 0);
    check_eq("rst_rfinput", RfInput, 0);
    check_eq("rst_funsel", RfFunSel, 0);
    check_eq("rst_rsel", RfRSel, 0);
    check_eq("rst_tsel", RfTSel, 0);
    check_eq("rst_o1sel", RfO1Sel, 0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check_eq("idle_busy", Busy, 0);
    check_eq("idle_sel", {RfRSel, RfTSel}, 0);

    // Load R1 with 0x5A, wrap T1 from 0xFF, operand change after grant, dropped Req.
    run_scn(1, 0, 2'b01, 3'd4, 8'h5A, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0);
    run_scn(1, 0, 2'b01, 3'd0, 8'hFF, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0);
    run_scn(0, 1, 2'b00, 3'd0, 8'h00, 2'b11, 3'd0, 8'h00, 0, 0, 0, 0);
    run_scn(1, 0, 2'b01, 3'd3, 8'h11, 2'b00, 3'd0, 8'h00, 0, 0, 1, 0);
    run_scn(0, 1, 2'b00, 3'd0, 8'h00, 2'b00, 3'd7, 8'h9C, 0, 1, 0, 0);
    run_scn(1, 1, 2'b01, 3'd6, 8'h42, 2'b01, 3'd1, 8'h24, 0, 0, 0, 0);

    // Reset while the operation is settling: no Ack, RF write from ISSUE stands.
    ReqA = 1'b1; OpA = 2'b11; AddrA = 3'd6; DataA = 8'h77;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b1; ReqA = 1'b0;
    #1;
    check_eq("midrst_busy", Busy, 0);
    check_eq("midrst_sel", {RfRSel, RfTSel}, 0);
    check_eq("midrst_ack", {AckA, AckB}, 0);
    check_eq("midrst_rddata", RdData, 0);
    exp_rf[6] = ref_result(2'b11, exp_rf[6], 8'h77);
    last_rd = '0;
    turn = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clock); #1;
      check_eq("postrst_ack", {AckA, AckB}, 0);
      check_eq("postrst_sel", {RfRSel, RfTSel}, 0);
    end
    check_rf();
    run_scn(1, 1, 2'b01, 3'd5, 8'h10, 2'b01, 3'd2, 8'h20, 0, 0, 0, 0);

    // Both requesters held: A increments R2, B decrements T3, grants alternate.
    s_op[0] = 2'b11; s_addr[0] = 3'd5; s_dat[0] = 8'($urandom);
    s_op[1] = 2'b10; s_addr[1] = 3'd2; s_dat[1] = 8'($urandom);
    OpA = s_op[0]; AddrA = s_addr[0]; DataA = s_dat[0]; ReqA = 1'b1;
    OpB = s_op[1]; AddrB = s_addr[1]; DataB = s_dat[1]; ReqB = 1'b1;
    who = turn ? 1 : 0; cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge Clock); #1;
      check_eq("both_ack", AckA & AckB, 0);
      if (c % 4 == 3) begin
        check_eq("rr_ack", (who == 0) ? AckA : AckB, 1);
        res = ref_result(s_op[who], exp_rf[s_addr[who]], s_dat[who]);
        exp_rf[s_addr[who]] = res;
        check_eq("rr_rddata", RdData, res);
        last_rd = res;
        cnt_a += int'(AckA);
        cnt_b += int'(AckB);
        who = 1 - who;
        if (c == 31) begin ReqA = 1'b0; ReqB = 1'b0; end
      end else begin
        check_eq("rr_busy", Busy, 1);
      end
    end
    turn = (who == 1);
    check_eq("rr_cnt_a", cnt_a, 4);
    check_eq("rr_cnt_b", cnt_b, 4);
    check_rf();

    for (int it = 0; it < 40; it++) begin
      ea = bit'($urandom_range(0, 1));
      eb = bit'($urandom_range(0, 1));
      if (!ea && !eb) ea = 1'b1;
      run_scn(ea, eb,
              2'($urandom), 3'($urandom), 8'($urandom),
              2'($urandom), 3'($urandom), 8'($urandom),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    check_rf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
